// File: rtl/imm_extend_pipe_pkg.sv
// Shared immediate-extension mode encodings, used by the decoder, the ALU control
// and this extend pipeline so all of them agree on the meaning of in_mode.
package imm_extend_pipe_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SEXT     = 2'd0,
        MODE_ZEXT     = 2'd1,
        MODE_SEXT_SHL = 2'd2,
        MODE_UPPER    = 2'd3
    } imm_mode_e;

    // Only the shifting/placing modes can lose information.
    function automatic logic mode_can_trunc(input logic [MODE_W-1:0] mode);
        return (mode == MODE_SEXT_SHL) || (mode == MODE_UPPER);
    endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Purely combinational immediate extender: sign/zero extension, scaled sign
// extension with overflow detection, and upper placement.
module imm_extend_core
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]   imm,
    input  logic [MODE_W-1:0] mode,
    output logic [OUT_W-1:0]  data,
    output logic              trunc
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] shl;
    logic [OUT_W-1:0] shl_restored;
    logic             shl_trunc;

    assign sext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext  = {{(OUT_W-IN_W){1'b0}}, imm};
    assign upper = {imm, {(OUT_W-IN_W){1'b0}}};
    assign shl   = sext << SHIFT;

    // Shifting back arithmetically recovers the original only when every
    // discarded bit matched the new sign bit.
    assign shl_restored = $signed(shl) >>> SHIFT;
    assign shl_trunc    = (shl_restored != sext);

    always_comb begin
        data  = sext;
        trunc = 1'b0;
        case (mode)
            MODE_SEXT: begin
                data = sext;
            end
            MODE_ZEXT: begin
                data = zext;
            end
            MODE_SEXT_SHL: begin
                data  = shl;
                trunc = shl_trunc;
            end
            MODE_UPPER: begin
                data = upper;
            end
            default: begin
                data  = sext;
                trunc = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a two-entry (output + skid) elastic buffer,
// a registered in_ready, and a wrapping completed-transfer counter.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_trunc,
    output logic [CNT_W-1:0]  xfer_count
);

    logic [OUT_W-1:0] ext_data;
    logic             ext_trunc;

    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic             skid_trunc;

    logic             accept;
    logic             complete;
    logic             out_free;

    logic             out_valid_nxt;
    logic [OUT_W-1:0] out_data_nxt;
    logic             out_trunc_nxt;
    logic             skid_valid_nxt;
    logic [OUT_W-1:0] skid_data_nxt;
    logic             skid_trunc_nxt;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_core (
        .imm   (in_imm),
        .mode  (in_mode),
        .data  (ext_data),
        .trunc (ext_trunc)
    );

    assign accept   = in_valid && in_ready;
    assign complete = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

    // in_ready is low whenever the skid holds an item, so an accept never
    // coincides with a full skid and the skid drains into the output first.
    always_comb begin
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        out_trunc_nxt  = out_trunc;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        skid_trunc_nxt = skid_trunc;
        if (out_free) begin
            if (skid_valid) begin
                out_valid_nxt  = 1'b1;
                out_data_nxt   = skid_data;
                out_trunc_nxt  = skid_trunc;
                skid_valid_nxt = 1'b0;
            end else if (accept) begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = ext_data;
                out_trunc_nxt = ext_trunc;
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
            skid_data_nxt  = ext_data;
            skid_trunc_nxt = ext_trunc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_trunc  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_trunc <= 1'b0;
            in_ready   <= 1'b0;
            xfer_count <= '0;
        end else begin
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            out_trunc  <= out_trunc_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            skid_trunc <= skid_trunc_nxt;
            in_ready   <= !skid_valid_nxt;
            if (complete) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning immediate input width; legal range 2..OUT_W-1.
REQ-002 SHALL have parameter OUT_W, default 32, meaning extended output width.
REQ-003 SHALL have parameter SHIFT, default 2, meaning left-shift amount for mode SEXT_SHL; legal range 0..OUT_W-1.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of the transfer counter.
REQ-005 SHALL have one clock and a synchronous, active-high reset: port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port in_valid  input  1  upstream holds a valid immediate.
REQ-008 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-009 SHALL have port in_imm  input  IN_W  raw immediate field.
REQ-010 SHALL have port in_mode  input  2  0=SEXT, 1=ZEXT, 2=SEXT_SHL, 3=UPPER.
REQ-011 SHALL have port out_valid  output  1  out_data/out_trunc valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-013 SHALL have port out_data  output  OUT_W  extended result.
REQ-014 SHALL have port out_trunc  output  1  set when SEXT_SHL/UPPER discarded non-sign/nonzero bits.
REQ-015 SHALL have port xfer_count  output  CNT_W  count of completed output transfers.

Function
REQ-016 SHALL treat a transfer as accepted on a rising edge where in_valid and in_ready are both 1, and completed where out_valid and out_ready are both 1.
REQ-017 SHALL compute SEXT as in_imm[IN_W-1] replicated into bits OUT_W-1..IN_W, in_imm in bits IN_W-1..0.
REQ-018 SHALL compute ZEXT as zeros in bits OUT_W-1..IN_W, in_imm in low bits.
REQ-019 SHALL compute SEXT_SHL as SEXT result shifted left by SHIFT, zero-filled, truncated to OUT_W; out_trunc=1 iff any discarded bit differs from the resulting out_data[OUT_W-1].
REQ-020 SHALL compute UPPER as in_imm placed in bits OUT_W-1..OUT_W-IN_W, lower bits zero; out_trunc=0.
REQ-021 SHALL force out_trunc=0 for SEXT and ZEXT.
REQ-022 SHALL compute the result combinationally at acceptance and register it; out_valid SHALL rise the cycle after acceptance (latency 1) when the output register was empty or draining.
REQ-023 SHALL contain an output register plus one skid entry (capacity 2), preserving strict FIFO order.
REQ-024 SHALL drive in_ready from a register: in_ready=1 iff the skid entry is empty; in_ready SHALL NOT depend combinationally on out_ready.
REQ-025 SHALL, when output register full and out_ready=0, place a new accepted item in the skid entry; in_ready SHALL be 0 the following cycle.
REQ-026 SHALL, on completion with skid full, move skid to output register in the same edge, keep out_valid=1, and raise in_ready next cycle.
REQ-027 SHALL, on simultaneous acceptance and completion with skid empty, load the new result into the output register with no bubble (sustained 1 item/cycle).
REQ-028 SHALL hold out_data, out_trunc stable while out_valid=1 and out_ready=0.
REQ-029 SHALL increment xfer_count by 1 per completion, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set out_valid=0, out_data=0, out_trunc=0, xfer_count=0, skid empty, in_ready=0 during reset and 1 the first cycle after reset deasserts.
REQ-031 SHALL discard any in-flight items on reset mid-operation; no accepted-but-incomplete item SHALL appear after reset.

Structure
REQ-032 SHALL take mode encodings (SEXT, ZEXT, SEXT_SHL, UPPER) from a shared package constant set used by the decoder and ALU-control blocks.
REQ-033 SHALL isolate the combinational extend/shift/trunc logic in one sub-module imm_extend_core (in_imm, in_mode -> data, trunc); the wrapper owns all state.

Verification
REQ-034 Bench SHALL drive, default params, out_ready=1: SEXT 16'h8001 -> 32'hFFFF8001; ZEXT 16'h8001 -> 32'h00008001; both out_trunc=0, one cycle latency.
REQ-035 Bench SHALL drive SEXT_SHL 16'hFFFF -> 32'hFFFFFFFC trunc 0; UPPER 16'h1234 -> 32'h12340000; with IN_W=31,SHIFT=2, SEXT_SHL 31'h20000000 -> 32'h80000000 trunc 1.
REQ-036 Bench SHALL hold out_ready=0 while offering items A,B,C: A,B accepted, in_ready=0 the cycle after B, C stalled; releasing out_ready yields A,B,C in order, back-to-back.
REQ-037 Bench SHALL stream 8 items with in_valid and out_ready constantly 1 -> 8 completions in 8 consecutive cycles, xfer_count=8.
REQ-038 Bench SHALL assert reset with both entries full -> out_valid=0, xfer_count=0 next cycle, no stale item emitted afterwards.
REQ-039 Bench SHALL, with CNT_W=4, complete 17 transfers -> xfer_count reads 15 then 0 then 1.
